// File: rtl/julia_colour_map.sv
// Pixel-rate colour stage: maps escape-time iteration counts to RGB through one of four
// palettes, with frame-synchronous palette rotation, and delays de/hs/vs to match.
module julia_colour_map #(
    parameter int   ITER_W = 8,
    parameter logic H_POL  = 1'b1,
    parameter logic V_POL  = 1'b1
) (
    input  logic              i_pix_clk,
    input  logic              i_rst_n,
    input  logic [ITER_W-1:0] i_iter,
    input  logic              i_escaped,
    input  logic              i_de,
    input  logic              i_hs,
    input  logic              i_vs,
    input  logic              i_cycle_en,
    input  logic [1:0]        i_speed,
    input  logic [1:0]        i_pal_sel,
    output logic [7:0]        o_red,
    output logic [7:0]        o_green,
    output logic [7:0]        o_blue,
    output logic              o_de,
    output logic              o_hs,
    output logic              o_vs
);

    // Frame event state
    logic       r_vs_prev;
    logic [7:0] r_off;
    logic [1:0] r_pal;
    logic       w_fe;
    logic [7:0] w_step;

    // Stage 1
    logic [7:0] r_s1_idx;
    logic       r_s1_blank;
    logic       r_s1_de;
    logic       r_s1_hs;
    logic       r_s1_vs;

    // Stage 2
    logic [7:0] r_s2_r;
    logic [7:0] r_s2_g;
    logic [7:0] r_s2_b;
    logic       r_s2_blank;
    logic       r_s2_de;
    logic       r_s2_hs;
    logic       r_s2_vs;

    // Palette lookup result
    logic [7:0] w_pal_r;
    logic [7:0] w_pal_g;
    logic [7:0] w_pal_b;

    // Only the low byte of the iteration count indexes the palette.
    if (ITER_W > 8) begin : g_iter_hi
        logic w_unused_iter_hi;
        assign w_unused_iter_hi = ^i_iter[ITER_W-1:8];
    end

    assign w_fe   = (i_vs == V_POL) && (r_vs_prev == !V_POL);
    assign w_step = 8'd1 << i_speed;

    always_ff @(posedge i_pix_clk) begin
        if (!i_rst_n) begin
            r_vs_prev <= !V_POL;
            r_off     <= 8'd0;
            r_pal     <= 2'd0;
        end else begin
            r_vs_prev <= i_vs;
            if (w_fe) begin
                r_pal <= i_pal_sel;
                if (i_cycle_en) begin
                    r_off <= r_off + w_step;
                end
            end
        end
    end

    always_ff @(posedge i_pix_clk) begin
        if (!i_rst_n) begin
            r_s1_idx   <= 8'd0;
            r_s1_blank <= 1'b1;
            r_s1_de    <= 1'b0;
            r_s1_hs    <= !H_POL;
            r_s1_vs    <= !V_POL;
        end else begin
            r_s1_idx   <= i_iter[7:0] + r_off;
            r_s1_blank <= !i_de || !i_escaped;
            r_s1_de    <= i_de;
            r_s1_hs    <= i_hs;
            r_s1_vs    <= i_vs;
        end
    end

    // Bit-slice forms of the palette formulas: 2i keeps the low 8 bits, 255-i is ~i.
    always_comb begin
        w_pal_r = r_s1_idx;
        w_pal_g = r_s1_idx;
        w_pal_b = r_s1_idx;
        case (r_pal)
            2'd1: begin
                w_pal_r = r_s1_idx[7] ? 8'd255 : {r_s1_idx[6:0], 1'b0};
                w_pal_g = r_s1_idx[7] ? {r_s1_idx[6:0], 1'b0} : 8'd0;
                w_pal_b = (r_s1_idx[7:6] == 2'b11) ? {r_s1_idx[5:0], 2'b00} : 8'd0;
            end
            2'd2: begin
                w_pal_r = 8'd0;
                w_pal_g = r_s1_idx >> 1;
                w_pal_b = r_s1_idx[7] ? 8'd255 : {r_s1_idx[6:0], 1'b0};
            end
            2'd3: begin
                w_pal_r = r_s1_idx;
                w_pal_g = ~r_s1_idx;
                w_pal_b = r_s1_idx[7] ? {~r_s1_idx[6:0], 1'b0} : {r_s1_idx[6:0], 1'b0};
            end
            default: begin
                w_pal_r = r_s1_idx;
                w_pal_g = r_s1_idx;
                w_pal_b = r_s1_idx;
            end
        endcase
    end

    always_ff @(posedge i_pix_clk) begin
        if (!i_rst_n) begin
            r_s2_r     <= 8'd0;
            r_s2_g     <= 8'd0;
            r_s2_b     <= 8'd0;
            r_s2_blank <= 1'b1;
            r_s2_de    <= 1'b0;
            r_s2_hs    <= !H_POL;
            r_s2_vs    <= !V_POL;
        end else begin
            r_s2_r     <= w_pal_r;
            r_s2_g     <= w_pal_g;
            r_s2_b     <= w_pal_b;
            r_s2_blank <= r_s1_blank;
            r_s2_de    <= r_s1_de;
            r_s2_hs    <= r_s1_hs;
            r_s2_vs    <= r_s1_vs;
        end
    end

    always_ff @(posedge i_pix_clk) begin
        if (!i_rst_n) begin
            o_red   <= 8'd0;
            o_green <= 8'd0;
            o_blue  <= 8'd0;
            o_de    <= 1'b0;
            o_hs    <= !H_POL;
            o_vs    <= !V_POL;
        end else begin
            o_red   <= r_s2_blank ? 8'd0 : r_s2_r;
            o_green <= r_s2_blank ? 8'd0 : r_s2_g;
            o_blue  <= r_s2_blank ? 8'd0 : r_s2_b;
            o_de    <= r_s2_de;
            o_hs    <= r_s2_hs;
            o_vs    <= r_s2_vs;
        end
    end

endmodule

// File: tb/tb_julia_colour_map.sv
// Directed bench for julia_colour_map: table-driven palette vectors plus hand-written
// sequences for reset, latency, rotation, palette latching and mid-frame reset.
module tb_julia_colour_map;

    localparam int ITER_W = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ITER_W-1:0] i_iter = '0;
    logic              i_escaped = 1'b0;
    logic              i_de = 1'b0;
    logic              i_hs = 1'b0;
    logic              i_vs = 1'b0;
    logic              i_cycle_en = 1'b0;
    logic [1:0]        i_speed = 2'd0;
    logic [1:0]        i_pal_sel = 2'd0;
    logic [7:0]        o_red;
    logic [7:0]        o_green;
    logic [7:0]        o_blue;
    logic              o_de;
    logic              o_hs;
    logic              o_vs;

    julia_colour_map #(.ITER_W(ITER_W), .H_POL(1'b1), .V_POL(1'b1)) dut (
        .i_pix_clk  (clk),
        .i_rst_n    (rst_n),
        .i_iter     (i_iter),
        .i_escaped  (i_escaped),
        .i_de       (i_de),
        .i_hs       (i_hs),
        .i_vs       (i_vs),
        .i_cycle_en (i_cycle_en),
        .i_speed    (i_speed),
        .i_pal_sel  (i_pal_sel),
        .o_red      (o_red),
        .o_green    (o_green),
        .o_blue     (o_blue),
        .o_de       (o_de),
        .o_hs       (o_hs),
        .o_vs       (o_vs)
    );

    always #5 clk = ~clk;

    // {r, g, b, de, hs, vs}
    localparam logic [26:0] IDLE = 27'd0;
    logic [26:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    string       label = "init";

    typedef struct packed {
        logic [1:0]        pal;
        logic [ITER_W-1:0] iter;
        logic              esc;
        logic              de;
        logic [7:0]        r;
        logic [7:0]        g;
        logic [7:0]        b;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic [1:0] pal, input int iter, input logic esc,
                                input logic de, input int r, input int g, input int b);
        vec_t v;
        v.pal  = pal;
        v.iter = ITER_W'(iter);
        v.esc  = esc;
        v.de   = de;
        v.r    = 8'(r);
        v.g    = 8'(g);
        v.b    = 8'(b);
        return v;
    endfunction

    task automatic compare(input logic [26:0] exp_v);
        logic [26:0] got;
        got = {o_red, o_green, o_blue, o_de, o_hs, o_vs};
        n_checks++;
        if (got !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got rgb=(%0d,%0d,%0d) de/hs/vs=%b%b%b, expected rgb=(%0d,%0d,%0d) de/hs/vs=%b%b%b",
                     label, got[26:19], got[18:11], got[10:3], got[2], got[1], got[0],
                     exp_v[26:19], exp_v[18:11], exp_v[10:3], exp_v[2], exp_v[1], exp_v[0]);
        end
    endtask

    // Drive one pixel; its result is compared three clock edges after it is driven.
    task automatic tick(input int iter, input logic esc, input logic de, input logic hs,
                        input logic vs, input int r, input int g, input int b);
        rst_n     = 1'b1;
        i_iter    = ITER_W'(iter);
        i_escaped = esc;
        i_de      = de;
        i_hs      = hs;
        i_vs      = vs;
        exp_q.push_back({8'(r), 8'(g), 8'(b), de, hs, vs});
        @(posedge clk);
        #1;
        if (exp_q.size() == 3) compare(exp_q.pop_front());
    endtask

    task automatic reset_tick();
        rst_n      = 1'b0;
        i_iter     = ITER_W'($urandom_range(0, 1023));
        i_escaped  = 1'($urandom_range(0, 1));
        i_de       = 1'($urandom_range(0, 1));
        i_hs       = 1'($urandom_range(0, 1));
        i_vs       = 1'($urandom_range(0, 1));
        i_cycle_en = 1'($urandom_range(0, 1));
        i_speed    = 2'($urandom_range(0, 3));
        i_pal_sel  = 2'($urandom_range(0, 3));
        @(posedge clk);
        #1;
        compare(IDLE);
        exp_q.delete();
        exp_q.push_back(IDLE);
        exp_q.push_back(IDLE);
        i_cycle_en = 1'b0;
        i_speed    = 2'd0;
        i_pal_sel  = 2'd0;
    endtask

    task automatic frame_pulse();
        tick(0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        tick(0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0);
        tick(0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0);
        tick(0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic idle_ticks(input int n);
        for (int k = 0; k < n; k++) tick(0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    initial begin
        logic [1:0] cur_pal;

        vecs[0]  = mk(2'd3, 100, 1'b0, 1'b1,   0,   0,   0);
        vecs[1]  = mk(2'd3, 100, 1'b1, 1'b0,   0,   0,   0);
        vecs[2]  = mk(2'd3, 100, 1'b1, 1'b1, 100, 155, 200);
        vecs[3]  = mk(2'd3,   0, 1'b1, 1'b1,   0, 255,   0);
        vecs[4]  = mk(2'd3, 127, 1'b1, 1'b1, 127, 128, 254);
        vecs[5]  = mk(2'd3, 128, 1'b1, 1'b1, 128, 127, 254);
        vecs[6]  = mk(2'd3, 255, 1'b1, 1'b1, 255,   0,   0);
        vecs[7]  = mk(2'd3, 868, 1'b1, 1'b1, 100, 155, 200);
        vecs[8]  = mk(2'd1,   0, 1'b1, 1'b1,   0,   0,   0);
        vecs[9]  = mk(2'd1, 100, 1'b1, 1'b1, 200,   0,   0);
        vecs[10] = mk(2'd1, 200, 1'b1, 1'b1, 255, 144,  32);
        vecs[11] = mk(2'd1, 255, 1'b1, 1'b1, 255, 254, 252);
        vecs[12] = mk(2'd1, 192, 1'b1, 1'b1, 255, 128,   0);
        vecs[13] = mk(2'd1, 200, 1'b0, 1'b1,   0,   0,   0);
        vecs[14] = mk(2'd2, 100, 1'b1, 1'b1,   0,  50, 200);
        vecs[15] = mk(2'd2, 200, 1'b1, 1'b1,   0, 100, 255);
        vecs[16] = mk(2'd2,   1, 1'b1, 1'b1,   0,   0,   2);
        vecs[17] = mk(2'd2, 127, 1'b1, 1'b1,   0,  63, 254);

        // Reset with random inputs, then the first pixel must emerge on the third edge.
        label = "reset_idle";
        for (int k = 0; k < 4; k++) reset_tick();

        label = "ramp_grey";
        for (int i = 0; i < 256; i++) begin
            tick(i, 1'b1, 1'b1, 1'((i >> 2) & 1), 1'b0, i, i, i);
        end
        idle_ticks(3);

        label = "palette_table";
        cur_pal = 2'd0;
        for (int k = 0; k < 18; k++) begin
            if (vecs[k].pal != cur_pal) begin
                i_pal_sel = vecs[k].pal;
                frame_pulse();
                cur_pal = vecs[k].pal;
            end
            tick(int'(vecs[k].iter), vecs[k].esc, vecs[k].de, 1'b1, 1'b0,
                 int'(vecs[k].r), int'(vecs[k].g), int'(vecs[k].b));
        end
        idle_ticks(3);

        // Palette select changes mid-frame only take effect at the next vsync edge.
        label = "pal_latch";
        i_pal_sel = 2'd0;
        frame_pulse();
        i_pal_sel = 2'd1;
        for (int k = 0; k < 4; k++) tick(200, 1'b1, 1'b1, 1'b0, 1'b0, 200, 200, 200);
        frame_pulse();
        for (int k = 0; k < 2; k++) tick(200, 1'b1, 1'b1, 1'b0, 1'b0, 255, 144, 32);
        idle_ticks(3);

        // Rotation: three frames of step 4 gives OFF = 12.
        label = "rotation";
        i_pal_sel  = 2'd0;
        i_cycle_en = 1'b1;
        i_speed    = 2'd2;
        for (int k = 0; k < 3; k++) frame_pulse();
        i_cycle_en = 1'b0;
        i_speed    = 2'd0;
        tick(250, 1'b1, 1'b1, 1'b0, 1'b0, 6, 6, 6);
        tick(243, 1'b1, 1'b1, 1'b0, 1'b0, 255, 255, 255);
        tick(244, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        tick(255, 1'b1, 1'b1, 1'b0, 1'b0, 11, 11, 11);
        i_speed = 2'd3;
        for (int k = 0; k < 2; k++) frame_pulse();
        label = "rotation_hold";
        tick(250, 1'b1, 1'b1, 1'b0, 1'b0, 6, 6, 6);
        tick(0, 1'b1, 1'b1, 1'b1, 1'b0, 12, 12, 12);
        idle_ticks(3);

        // Mid-frame reset with OFF = 12 and PAL = 3 returns to grey with OFF = 0.
        label = "pre_reset_ramp";
        i_pal_sel = 2'd3;
        frame_pulse();
        tick(50, 1'b1, 1'b1, 1'b0, 1'b0, 62, 193, 124);
        tick(50, 1'b1, 1'b1, 1'b0, 1'b0, 62, 193, 124);
        tick(50, 1'b1, 1'b1, 1'b0, 1'b0, 62, 193, 124);
        label = "mid_reset_idle";
        reset_tick();
        label = "post_reset";
        tick(5, 1'b1, 1'b1, 1'b0, 1'b0, 5, 5, 5);
        tick(250, 1'b1, 1'b1, 1'b0, 1'b0, 250, 250, 250);
        idle_ticks(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
